// File: rtl/arb_pkg.sv
// Shared definitions for mem_arbiter: state encoding, NOP fill word and
// default starvation/timeout limits.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        DM_BUSY = 2'd2
    } arb_state_e;

    localparam logic [31:0] NOP_INSN       = 32'h0000_0013;
    localparam int          STARVE_MAX_DEF = 4;
    localparam int          TIMEOUT_DEF    = 16;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a unified single-port memory.
// Define ARB_TIMEOUT_EN to add the mem_ack timeout abort with bus_err.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    input  logic [3:0]  i_dm_mask,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_if_valid,
    output logic        o_dm_valid,
    output logic [31:0] o_if_rdata,
    output logic [31:0] o_dm_rdata,
    output logic        o_stall_if,
    output logic        o_stall_dm,
    output logic        o_bus_err
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_IF_BUSY = IF_BUSY;
    localparam logic [1:0] S_DM_BUSY = DM_BUSY;

    localparam int             SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]  STARVE_TOP = SW'(STARVE_MAX);

    logic [1:0]    r_state;
    logic [SW-1:0] r_starve;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_mask;
    logic          r_if_valid;
    logic          r_dm_valid;
    logic [31:0]   r_if_rdata;
    logic [31:0]   r_dm_rdata;

    logic          w_can_grant;
    logic          w_grant_if;
    logic          w_grant_dm;
    logic          w_abort;

    // The cycle carrying a valid pulse is the turnaround: the finishing
    // requester still shows its old request then, so nothing is granted.
    assign w_can_grant = (r_state == S_IDLE) && !r_if_valid && !r_dm_valid;
    assign w_grant_dm  = w_can_grant && i_dm_req &&
                         !(i_if_req && (r_starve == STARVE_TOP));
    assign w_grant_if  = w_can_grant && i_if_req && !w_grant_dm;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'h0;
            r_mem_wdata <= 32'h0;
            r_mem_mask  <= 4'h0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_dm_rdata  <= 32'h0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_dm) begin
                        r_state     <= S_DM_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_dm_we;
                        r_mem_addr  <= i_dm_addr;
                        r_mem_wdata <= i_dm_wdata;
                        r_mem_mask  <= i_dm_mask;
                    end else if (w_grant_if) begin
                        r_state     <= S_IF_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_if_addr;
                        r_mem_wdata <= 32'h0;
                        r_mem_mask  <= 4'hF;
                    end
                end
                S_IF_BUSY: begin
                    if (i_mem_ack || w_abort) begin
                        r_if_rdata <= i_mem_ack ? i_mem_rdata : NOP_INSN;
                        r_if_valid <= 1'b1;
                        r_state    <= S_IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                    end
                end
                S_DM_BUSY: begin
                    if (i_mem_ack) begin
                        if (!r_mem_we) begin
                            r_dm_rdata <= i_mem_rdata;
                        end
                        r_dm_valid <= 1'b1;
                        r_state    <= S_IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                    end else if (w_abort) begin
                        r_dm_rdata <= NOP_INSN;
                        r_dm_valid <= 1'b1;
                        r_state    <= S_IDLE;
                        r_mem_req  <= 1'b0;
                        r_mem_we   <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                end
            endcase
        end
    end

    // Consecutive data grants seen while a fetch is waiting.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_starve <= '0;
        end else if (w_grant_if || !i_if_req) begin
            r_starve <= '0;
        end else if (w_grant_dm && (r_starve != STARVE_TOP)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_END = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_tmo;
    logic          r_bus_err;

    assign w_abort = (r_state != S_IDLE) && !i_mem_ack && (r_tmo == TMO_END);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tmo     <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_abort;
            if ((r_state == S_IDLE) || i_mem_ack || w_abort) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    assign o_bus_err = r_bus_err;
`else
    assign w_abort   = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_mask  = r_mem_mask;
    assign o_if_valid  = r_if_valid;
    assign o_dm_valid  = r_dm_valid;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_stall_if  = i_if_req & ~r_if_valid;
    assign o_stall_dm  = i_dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, a memory
// responder with programmable ack delay, and directed scenarios.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_mask;
    logic        o_mem_req, o_mem_we, o_if_valid, o_dm_valid;
    logic        o_stall_if, o_stall_dm, o_bus_err;
    logic [31:0] o_mem_addr, o_mem_wdata, o_if_rdata, o_dm_rdata;
    logic [3:0]  o_mem_mask;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr),
        .i_dm_wdata(dm_wdata), .i_dm_mask(dm_mask),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
        .o_if_valid(o_if_valid), .o_dm_valid(o_dm_valid),
        .o_if_rdata(o_if_rdata), .o_dm_rdata(o_dm_rdata),
        .o_stall_if(o_stall_if), .o_stall_dm(o_stall_dm), .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[15:0], 16'hC0DE};
    endfunction

    // Memory responder: ack arrives ack_dly cycles after mem_req is first seen.
    int ack_dly   = 1;
    int rsp_cnt   = 0;
    bit force_ack = 0;
    always @(negedge clk) begin
        if (rst || !o_mem_req) begin
            rsp_cnt   = 0;
            mem_ack   = force_ack;
            mem_rdata = 32'hDEAD_BEEF;
        end else begin
            rsp_cnt++;
            if (rsp_cnt == ack_dly + 1) begin
                mem_ack   = 1'b1;
                mem_rdata = o_mem_we ? 32'hDEAD_BEEF : mem_word(o_mem_addr);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Reference model: owner 0 = none, 1 = fetch, 2 = data.
    int          owner = 0;
    int          starve = 0;
    int          busy_cyc = 0;
    bit          may_grant, take_dm, take_if;
    logic        e_mem_req = 0, e_mem_we = 0, e_if_valid = 0, e_dm_valid = 0, e_bus_err = 0;
    logic [31:0] e_mem_addr = 0, e_mem_wdata = 0, e_if_rdata = 0, e_dm_rdata = 0;
    logic [3:0]  e_mem_mask = 0;

    always @(posedge clk) begin
        if (rst) begin
            owner = 0; starve = 0; busy_cyc = 0;
            e_mem_req = 0; e_mem_we = 0; e_if_valid = 0; e_dm_valid = 0; e_bus_err = 0;
            e_mem_addr = 0; e_mem_wdata = 0; e_mem_mask = 0; e_if_rdata = 0; e_dm_rdata = 0;
        end else begin
            may_grant  = (owner == 0) && !e_if_valid && !e_dm_valid;
            e_if_valid = 0;
            e_dm_valid = 0;
            e_bus_err  = 0;
            if (owner != 0) begin
                if (mem_ack) begin
                    if (owner == 1) begin
                        e_if_rdata = mem_rdata; e_if_valid = 1;
                    end else begin
                        if (!e_mem_we) e_dm_rdata = mem_rdata;
                        e_dm_valid = 1;
                    end
                    owner = 0; e_mem_req = 0; e_mem_we = 0; busy_cyc = 0;
                end else begin
                    busy_cyc++;
`ifdef ARB_TIMEOUT_EN
                    if (busy_cyc == TIMEOUT) begin
                        if (owner == 1) begin e_if_rdata = 32'h13; e_if_valid = 1; end
                        else begin e_dm_rdata = 32'h13; e_dm_valid = 1; end
                        e_bus_err = 1; owner = 0; e_mem_req = 0; e_mem_we = 0; busy_cyc = 0;
                    end
`endif
                end
            end
            take_dm = may_grant && dm_req && !(if_req && starve == STARVE_MAX);
            take_if = may_grant && if_req && !take_dm;
            if (take_dm) begin
                owner = 2; e_mem_req = 1; e_mem_we = dm_we;
                e_mem_addr = dm_addr; e_mem_wdata = dm_wdata; e_mem_mask = dm_mask;
            end else if (take_if) begin
                owner = 1; e_mem_req = 1; e_mem_we = 0; e_mem_addr = if_addr;
            end
            if (take_if || !if_req) starve = 0;
            else if (take_dm && starve < STARVE_MAX) starve++;
        end
    end

    always @(negedge clk) begin
        #1;
        chk("mem_req", o_mem_req, e_mem_req);
        if (e_mem_req) begin
            chk("mem_addr", o_mem_addr, e_mem_addr);
            chk("mem_we", o_mem_we, e_mem_we);
            if (owner == 2) begin
                chk("mem_wdata", o_mem_wdata, e_mem_wdata);
                chk("mem_mask", o_mem_mask, e_mem_mask);
            end
        end
        chk("if_valid", o_if_valid, e_if_valid);
        chk("dm_valid", o_dm_valid, e_dm_valid);
        chk("if_rdata", o_if_rdata, e_if_rdata);
        chk("dm_rdata", o_dm_rdata, e_dm_rdata);
        chk("stall_if", o_stall_if, if_req & ~e_if_valid);
        chk("stall_dm", o_stall_dm, dm_req & ~e_dm_valid);
        chk("bus_err", o_bus_err, e_bus_err);
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    logic [31:0] grants[$];
    logic [31:0] exp_grants[7] = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h40, 32'h110, 32'h114};
    bit          prev_req;
    int          dm_done;
    bit          done;

    initial begin
        rst = 1; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; dm_mask = 0;
        mem_ack = 0; mem_rdata = 0;

        repeat (3) tick();
        chk("rst_mem_req", o_mem_req, 1'b0);
        chk("rst_mem_we", o_mem_we, 1'b0);
        chk("rst_mem_addr", o_mem_addr, 32'h0);
        chk("rst_mem_wdata", o_mem_wdata, 32'h0);
        chk("rst_mem_mask", o_mem_mask, 4'h0);
        chk("rst_if_rdata", o_if_rdata, 32'h0);
        chk("rst_dm_rdata", o_dm_rdata, 32'h0);
        rst = 0;
        repeat (2) tick();

        // Single fetch with a one-cycle memory.
        ack_dly = 1;
        tick(); if_req = 1; if_addr = 32'h10; #1;
        chk("f_stall_c0", o_stall_if, 1'b1);
        tick(); chk("f_mem_req_c1", o_mem_req, 1'b1); chk("f_mem_addr_c1", o_mem_addr, 32'h10);
        chk("f_stall_c1", o_stall_if, 1'b1);
        tick(); chk("f_stall_c2", o_stall_if, 1'b1); chk("f_valid_c2", o_if_valid, 1'b0);
        tick(); chk("f_valid_c3", o_if_valid, 1'b1); chk("f_rdata_c3", o_if_rdata, 32'h0050_0093);
        chk("f_stall_c3", o_stall_if, 1'b0);
        if_req = 0;
        tick(); chk("f_valid_c4", o_if_valid, 1'b0);

        // Simultaneous fetch and load: data first.
        tick(); if_req = 1; if_addr = 32'h14; dm_req = 1; dm_we = 0; dm_addr = 32'h20;
        tick(); chk("s_addr_c1", o_mem_addr, 32'h20); chk("s_we_c1", o_mem_we, 1'b0);
        tick();
        tick(); chk("s_dvalid_c3", o_dm_valid, 1'b1); chk("s_drdata_c3", o_dm_rdata, 32'h0020_C0DE);
        chk("s_stall_if_c3", o_stall_if, 1'b1);
        dm_req = 0;
        tick(); chk("s_turn_c4", o_mem_req, 1'b0); chk("s_stall_if_c4", o_stall_if, 1'b1);
        tick(); chk("s_req_c5", o_mem_req, 1'b1); chk("s_addr_c5", o_mem_addr, 32'h14);
        tick(); chk("s_stall_if_c6", o_stall_if, 1'b1);
        tick(); chk("s_ivalid_c7", o_if_valid, 1'b1); chk("s_irdata_c7", o_if_rdata, 32'h0014_C0DE);
        chk("s_stall_if_c7", o_stall_if, 1'b0);
        if_req = 0;
        tick();

        // Store with a three-cycle memory.
        ack_dly = 3;
        tick(); dm_req = 1; dm_we = 1; dm_addr = 32'h30; dm_wdata = 32'h0000_ABCD; dm_mask = 4'b0011;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("st_req", o_mem_req, 1'b1);
            chk("st_we", o_mem_we, 1'b1);
            chk("st_mask", o_mem_mask, 4'b0011);
            chk("st_wdata", o_mem_wdata, 32'h0000_ABCD);
            chk("st_valid_early", o_dm_valid, 1'b0);
        end
        tick(); chk("st_valid_c5", o_dm_valid, 1'b1); chk("st_rdata_kept", o_dm_rdata, 32'h0020_C0DE);
        dm_req = 0; dm_we = 0; dm_mask = 4'h0;
        tick(); chk("st_req_drop", o_mem_req, 1'b0);

        // Stray ack with nothing outstanding.
        force_ack = 1;
        repeat (3) begin
            tick();
            chk("idle_ack_req", o_mem_req, 1'b0);
            chk("idle_ack_ivalid", o_if_valid, 1'b0);
            chk("idle_ack_dvalid", o_dm_valid, 1'b0);
        end
        force_ack = 0;
        tick();

        // Starvation: six loads back to back while a fetch waits.
        ack_dly = 1;
        tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h100; if_req = 1; if_addr = 32'h40;
        prev_req = 0; dm_done = 0; done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            tick();
            if (o_mem_req && !prev_req) grants.push_back(o_mem_addr);
            prev_req = o_mem_req;
            if (o_if_valid) if_req = 0;
            if (o_dm_valid) begin
                dm_done++;
                dm_addr = dm_addr + 32'h4;
                if (dm_done == 6) begin
                    dm_req = 0;
                    done = 1;
                end
            end
        end
        chk("starve_done", 32'(done), 32'd1);
        chk("starve_ngrants", grants.size(), 32'd7);
        for (int g = 0; g < 7; g++) begin
            if (g < grants.size()) chk("starve_order", grants[g], exp_grants[g]);
        end
        repeat (2) tick();

        // Reset while a load is outstanding.
        ack_dly = 5;
        tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h50;
        tick(); chk("rm_req_c1", o_mem_req, 1'b1);
        tick(); rst = 1; dm_req = 0;
        tick(); chk("rm_req_after", o_mem_req, 1'b0); chk("rm_drdata", o_dm_rdata, 32'h0);
        rst = 0;
        repeat (6) begin
            tick();
            chk("rm_no_valid", o_dm_valid, 1'b0);
        end

`ifdef ARB_TIMEOUT_EN
        ack_dly = 1000;
        done = 0;
        tick(); if_req = 1; if_addr = 32'h60;
        for (int n = 1; n <= 40 && !done; n++) begin
            tick();
            if (o_bus_err) begin
                done = 1;
                chk("tmo_cycle", n, 32'd17);
                chk("tmo_ivalid", o_if_valid, 1'b1);
                chk("tmo_irdata", o_if_rdata, 32'h0000_0013);
                if_req = 0;
            end
        end
        chk("tmo_seen", 32'(done), 32'd1);
        if_req = 0;
        repeat (2) tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the number of consecutive data-port grants allowed while fetch is pending before fetch wins once.
REQ-002 Parameter TIMEOUT, default 16, is the cycles to wait for mem_ack before abort; it is used only with ARB_TIMEOUT_EN.
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 if_req  in  1  fetch request; held until if_valid.
REQ-006 if_addr  in  32  fetch byte address, word-aligned.
REQ-007 dm_req  in  1  load/store request; held until dm_valid.
REQ-008 dm_we  in  1  1=store, 0=load.
REQ-009 dm_addr  in  32  data byte address.
REQ-010 dm_wdata  in  32  store data, already lane-aligned.
REQ-011 dm_mask  in  4  byte-lane write enables.
REQ-012 mem_req, mem_we  out  1  request and write strobe to the unified single-port memory.
REQ-013 mem_addr, mem_wdata  out  32  address and write data to memory.
REQ-014 mem_mask  out  4  byte-lane enables to memory.
REQ-015 mem_ack  in  1  memory completion, 1 or more cycles after mem_req.
REQ-016 mem_rdata  in  32  read data, valid with mem_ack.
REQ-017 if_valid, dm_valid  out  1  one-cycle completion pulses.
REQ-018 if_rdata, dm_rdata  out  32  registered read data, valid with the matching valid pulse.
REQ-019 stall_if, stall_dm  out  1  stall to the fetch and memory pipeline stages.
REQ-020 bus_err  out  1  timeout abort pulse (ARB_TIMEOUT_EN only, else tied 0).

Function
REQ-021 The FSM has states IDLE, IF_BUSY and DM_BUSY.
REQ-022 IDLE grant priority: dm_req over if_req, unless starve_cnt==STARVE_MAX and if_req=1, in which case fetch is granted.
REQ-023 On grant, the transaction signals are registered to mem_* in the same edge, mem_req=1 from the next cycle, and the FSM moves to IF_BUSY or DM_BUSY.
REQ-024 mem_req and the mem_* outputs are held stable until mem_ack.
REQ-025 On mem_ack: capture mem_rdata into the granted port's rdata, pulse its valid for 1 cycle, drop mem_req and return to IDLE (one idle turnaround cycle).
REQ-026 starve_cnt is saturating with width clog2(STARVE_MAX+1): it increments on each DM grant while if_req=1, clears on any IF grant, and clears when if_req=0.
REQ-027 stall_if = if_req & ~if_valid; stall_dm = dm_req & ~dm_valid.
REQ-028 Minimum latency is req to valid = 3 cycles with a 1-cycle mem_ack.
REQ-029 Stores return dm_valid and leave dm_rdata unchanged.
REQ-030 When both requests drop in IDLE, mem_req stays 0 and there is no grant.
REQ-031 mem_ack in IDLE is ignored.
REQ-032 Requests are not re-sampled in BUSY; request changes mid-transaction have no effect.

Reset
REQ-033 reset takes priority over all other inputs, including mid-transaction: state goes to IDLE and mem_req, mem_we, if_valid, dm_valid, bus_err, starve_cnt and the timeout counter clear to 0.
REQ-034 if_rdata, dm_rdata, mem_addr, mem_wdata and mem_mask reset to 0.
REQ-035 An outstanding transaction is discarded on reset; no valid pulse is produced for it.

Configuration
REQ-036 With ARB_TIMEOUT_EN defined, a counter runs in BUSY states.
REQ-037 If it reaches TIMEOUT without mem_ack, the FSM aborts to IDLE, pulses bus_err plus the granted valid for 1 cycle, and sets the granted rdata to 32'h0000_0013 (NOP).
REQ-038 The counter clears on IDLE entry.
REQ-039 Without ARB_TIMEOUT_EN, the FSM waits indefinitely for mem_ack, bus_err is constant 0, and no counter logic is present.

Structure
REQ-040 Package arb_pkg holds the state enum (IDLE, IF_BUSY, DM_BUSY), the NOP constant and the default STARVE_MAX/TIMEOUT values.
REQ-041 mem_arbiter is a single module with no sub-modules; the starvation counter is inline.

Verification
REQ-042 Single fetch: if_req=1, if_addr=0x10, mem_ack 1 cycle after mem_req, mem_rdata=0x00500093 -> if_valid at cycle 3, if_rdata=0x00500093, stall_if high cycles 0-2.
REQ-043 Simultaneous requests: if_req=dm_req=1, load of 0x20 -> DM is granted first, then IF; stall_if is held until the second completion.
REQ-044 Starvation: dm_req held high for 6 transactions with if_req high -> after 4 DM grants, IF is granted, then DM resumes.
REQ-045 Store: dm_we=1, dm_mask=4'b0011, dm_wdata=0xABCD -> mem_we=1 and mem_mask=0011 held until ack, dm_valid pulses, dm_rdata is unchanged.
REQ-046 Reset mid-transaction: reset asserted in DM_BUSY before ack -> next cycle IDLE, mem_req=0, and no dm_valid is produced.
REQ-047 Timeout (ARB_TIMEOUT_EN, TIMEOUT=16): mem_ack never asserted -> at 16 cycles bus_err=1, if_valid=1, if_rdata=0x00000013.
